// File: rtl/dpa_timebase_seq_if.sv
// Image-memory bus between the timebase sequencer (master) and the memory (slave).
// The sequencer drives the bus only while bus_own is high.
interface dpa_timebase_seq_if;
  logic [19:0] IM_A;
  logic [23:0] IM_Q;
  logic        IM_WEN;
  logic        bus_own;

  modport master (
    output IM_A,
    output IM_WEN,
    output bus_own,
    input  IM_Q
  );

  modport slave (
    input  IM_A,
    input  IM_WEN,
    input  bus_own,
    output IM_Q
  );
endinterface

// File: rtl/dpa_timebase_seq.sv
// Album header fetch, HH:MM:SS timekeeping and slideshow sequencing with
// req/ack handshakes toward the time and photo renderers.
module dpa_timebase_seq #(
  parameter int CLK_PER_SEC   = 1000000,
  parameter int MAX_PHOTOS    = 4,
  parameter int SEC_PER_PHOTO = 2,
  parameter int HDR_BASE      = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  dpa_timebase_seq_if.master        im,
  output logic                      hdr_valid,
  output logic [23:0]               fb_addr,
  output logic [4:0]                photo_cnt,
  output logic [3:0]                photo_idx,
  output logic [23:0]               photo_addr,
  output logic [23:0]               photo_size,
  output logic [4:0]                hour,
  output logic [5:0]                minute,
  output logic [5:0]                second,
  output logic                      time_req,
  input  logic                      time_ack,
  output logic                      photo_req,
  input  logic                      photo_ack,
  output logic                      overrun
);

  localparam int N_WORDS = 3 + 2 * MAX_PHOTOS;
  localparam int K_W     = $clog2(N_WORDS + 1);
  localparam int SC_W    = $clog2(CLK_PER_SEC);
  localparam int PH_W    = $clog2(SEC_PER_PHOTO + 1);

  localparam logic [K_W-1:0]  K_LAST  = K_W'(N_WORDS);
  localparam logic [SC_W-1:0] SC_LAST = SC_W'(CLK_PER_SEC - 1);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(SEC_PER_PHOTO - 1);
  localparam logic [19:0]     BASE_A  = 20'(HDR_BASE);
  localparam logic [4:0]      CNT_MAX = 5'(MAX_PHOTOS);

  typedef enum logic [1:0] {
    ST_FETCH,
    ST_START,
    ST_RUN
  } state_e;

  state_e           state_q, state_d;
  logic [K_W-1:0]   k_q, k_d;
  logic [SC_W-1:0]  sc_q, sc_d;
  logic [PH_W-1:0]  ph_q, ph_d;
  logic [4:0]       hh_q, hh_d;
  logic [5:0]       mm_q, mm_d;
  logic [5:0]       ss_q, ss_d;
  logic [23:0]      fb_q, fb_d;
  logic [4:0]       cnt_q, cnt_d;
  logic [3:0]       idx_q, idx_d;
  logic [23:0]      addr_q [MAX_PHOTOS];
  logic [23:0]      addr_d [MAX_PHOTOS];
  logic [23:0]      size_q [MAX_PHOTOS];
  logic [23:0]      size_d [MAX_PHOTOS];
  logic             hv_q, hv_d;
  logic             treq_q, treq_d;
  logic             preq_q, preq_d;
  logic             ovr_q, ovr_d;

  logic             tick;
  logic             time_evt;
  logic             photo_evt;
  int               word_idx;
  int               slot_rel;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d    = state_q;
    k_d        = k_q;
    sc_d       = sc_q;
    ph_d       = ph_q;
    hh_d       = hh_q;
    mm_d       = mm_q;
    ss_d       = ss_q;
    fb_d       = fb_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    addr_d     = addr_q;
    size_d     = size_q;
    hv_d       = hv_q;
    tick       = 1'b0;
    time_evt   = 1'b0;
    photo_evt  = 1'b0;
    word_idx   = int'(k_q) - 1;
    slot_rel   = word_idx - 3;
    im.IM_A    = '0;
    im.IM_WEN  = 1'b1;
    im.bus_own = 1'b0;

    unique case (state_q)
      ST_FETCH: begin
        im.bus_own = 1'b1;
        im.IM_A    = BASE_A + 20'(k_q);
        // Read data lags the address by one cycle, so cycle k captures word k-1.
        if (k_q != '0) begin
          unique case (word_idx)
            0: begin
              hh_d = (im.IM_Q[23:16] > 8'd23) ? 5'd0 : im.IM_Q[20:16];
              mm_d = (im.IM_Q[15:8]  > 8'd59) ? 6'd0 : im.IM_Q[13:8];
              ss_d = (im.IM_Q[7:0]   > 8'd59) ? 6'd0 : im.IM_Q[5:0];
            end
            1: fb_d = im.IM_Q;
            2: cnt_d = (im.IM_Q > 24'(MAX_PHOTOS)) ? CNT_MAX : im.IM_Q[4:0];
            default: begin
              for (int s = 0; s < MAX_PHOTOS; s++) begin
                if (slot_rel == 2 * s)     addr_d[s] = im.IM_Q;
                if (slot_rel == 2 * s + 1) size_d[s] = im.IM_Q;
              end
            end
          endcase
        end
        if (k_q == K_LAST) state_d = ST_START;
        else               k_d     = k_q + 1'b1;
      end

      ST_START: begin
        hv_d      = 1'b1;
        time_evt  = 1'b1;
        photo_evt = (cnt_q != 5'd0);
        idx_d     = '0;
        sc_d      = '0;
        ph_d      = '0;
        state_d   = ST_RUN;
      end

      ST_RUN: begin
        tick = (sc_q == SC_LAST);
        sc_d = tick ? '0 : sc_q + 1'b1;
        if (tick) begin
          time_evt = 1'b1;
          if (ss_q == 6'd59) begin
            ss_d = 6'd0;
            if (mm_q == 6'd59) begin
              mm_d = 6'd0;
              hh_d = (hh_q == 5'd23) ? 5'd0 : hh_q + 5'd1;
            end else begin
              mm_d = mm_q + 6'd1;
            end
          end else begin
            ss_d = ss_q + 6'd1;
          end

          if (ph_q == PH_LAST) begin
            ph_d = '0;
            if (cnt_q != 5'd0) begin
              photo_evt = 1'b1;
              idx_d     = (({1'b0, idx_q} + 5'd1) == cnt_q) ? 4'd0 : idx_q + 4'd1;
            end
          end else begin
            ph_d = ph_q + 1'b1;
          end
        end
      end

      default: state_d = ST_FETCH;
    endcase

    // A pending req is kept (coalesced) when a new event lands before its ack.
    treq_d = (treq_q & ~time_ack)  | time_evt;
    preq_d = (preq_q & ~photo_ack) | photo_evt;
    ovr_d  = ovr_q
           | (time_evt  & treq_q & ~time_ack)
           | (photo_evt & preq_q & ~photo_ack);
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    if (reset) begin
      state_q <= ST_FETCH;
      k_q     <= '0;
      sc_q    <= '0;
      ph_q    <= '0;
      hh_q    <= '0;
      mm_q    <= '0;
      ss_q    <= '0;
      fb_q    <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      hv_q    <= 1'b0;
      treq_q  <= 1'b0;
      preq_q  <= 1'b0;
      ovr_q   <= 1'b0;
      // NOTE: the slot table is reset because photo_addr/photo_size read it
      // directly and must show zero straight out of reset.
      for (int s = 0; s < MAX_PHOTOS; s++) begin
        addr_q[s] <= '0;
        size_q[s] <= '0;
      end
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      sc_q    <= sc_d;
      ph_q    <= ph_d;
      hh_q    <= hh_d;
      mm_q    <= mm_d;
      ss_q    <= ss_d;
      fb_q    <= fb_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      hv_q    <= hv_d;
      treq_q  <= treq_d;
      preq_q  <= preq_d;
      ovr_q   <= ovr_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
    end
  end

  always_comb begin
    photo_addr = '0;
    photo_size = '0;
    for (int s = 0; s < MAX_PHOTOS; s++) begin
      if (idx_q == 4'(s)) begin
        photo_addr = addr_q[s];
        photo_size = size_q[s];
      end
    end
  end

  assign hdr_valid = hv_q;
  assign fb_addr   = fb_q;
  assign photo_cnt = cnt_q;
  assign photo_idx = idx_q;
  assign hour      = hh_q;
  assign minute    = mm_q;
  assign second    = ss_q;
  assign time_req  = treq_q;
  assign photo_req = preq_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_dpa_timebase_seq.sv
// Scoreboard bench for dpa_timebase_seq: stimulus queues expected header, time
// and photo events; a monitor pops and compares them as the DUT produces them.
module tb_dpa_timebase_seq;

  typedef struct packed {
    int lat;
    int hms;
    int cnt;
    int fb;
    int addr;
    int size;
    bit preq;
  } hev_t;

  typedef struct packed {
    int off;
    int hms;
  } tev_t;

  typedef struct packed {
    int off;
    int idx;
    int addr;
    int size;
  } pev_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        time_ack = 1'b1;
  logic        photo_ack = 1'b1;
  logic        hdr_valid;
  logic [23:0] fb_addr;
  logic [4:0]  photo_cnt;
  logic [3:0]  photo_idx;
  logic [23:0] photo_addr;
  logic [23:0] photo_size;
  logic [4:0]  hour;
  logic [5:0]  minute;
  logic [5:0]  second;
  logic        time_req;
  logic        photo_req;
  logic        overrun;

  logic [23:0] mem [64];
  int          cyc = 0;
  int          fetch_cyc = 0;
  int          hv_cyc = 0;
  int          total = 0;
  int          bad = 0;

  hev_t        hq[$];
  tev_t        tq[$];
  pev_t        pq[$];
  hev_t        he;
  tev_t        te;
  pev_t        pe;
  bit          hv_prev = 1'b0;
  bit          preq_seen = 1'b0;
  int          t_prev = 0;
  logic [3:0]  idx_prev = '0;

  dpa_timebase_seq_if im ();

  dpa_timebase_seq #(
    .CLK_PER_SEC   (10),
    .MAX_PHOTOS    (4),
    .SEC_PER_PHOTO (2),
    .HDR_BASE      (0)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .im         (im),
    .hdr_valid  (hdr_valid),
    .fb_addr    (fb_addr),
    .photo_cnt  (photo_cnt),
    .photo_idx  (photo_idx),
    .photo_addr (photo_addr),
    .photo_size (photo_size),
    .hour       (hour),
    .minute     (minute),
    .second     (second),
    .time_req   (time_req),
    .time_ack   (time_ack),
    .photo_req  (photo_req),
    .photo_ack  (photo_ack),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    im.IM_Q <= mem[im.IM_A[5:0]];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d (0x%0h) expected=%0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic int hms_now();
    return int'(hour) * 10000 + int'(minute) * 100 + int'(second);
  endfunction

  // Monitor: header rise, time change and photo change each pop their queue.
  always @(negedge clk) begin
    if (photo_req === 1'b1) preq_seen = 1'b1;
    if (hdr_valid === 1'b1 && !hv_prev) begin
      hv_cyc = cyc;
      check("hdr_expected", hq.size() != 0, 1);
      if (hq.size() != 0) begin
        he = hq.pop_front();
        check("hdr_latency", cyc - fetch_cyc, he.lat);
        check("hdr_time", hms_now(), he.hms);
        check("hdr_photo_cnt", photo_cnt, he.cnt);
        check("hdr_fb_addr", fb_addr, he.fb);
        check("hdr_photo_addr", photo_addr, he.addr);
        check("hdr_photo_size", photo_size, he.size);
        check("hdr_photo_idx", photo_idx, 0);
        check("hdr_time_req", time_req, 1);
        check("hdr_photo_req", photo_req, he.preq);
        check("hdr_bus_released", im.bus_own, 0);
        check("hdr_im_a_idle", im.IM_A, 0);
      end
      t_prev   = hms_now();
      idx_prev = photo_idx;
    end else if (hdr_valid === 1'b1) begin
      if (hms_now() != t_prev) begin
        check("time_evt_expected", tq.size() != 0, 1);
        if (tq.size() != 0) begin
          te = tq.pop_front();
          check("time_offset", cyc - hv_cyc, te.off);
          check("time_value", hms_now(), te.hms);
          check("time_req_on_tick", time_req, 1);
        end
        t_prev = hms_now();
      end
      if (photo_idx != idx_prev) begin
        check("photo_evt_expected", pq.size() != 0, 1);
        if (pq.size() != 0) begin
          pe = pq.pop_front();
          check("photo_offset", cyc - hv_cyc, pe.off);
          check("photo_idx", photo_idx, pe.idx);
          check("photo_addr", photo_addr, pe.addr);
          check("photo_size", photo_size, pe.size);
          check("photo_req_on_change", photo_req, 1);
        end
        idx_prev = photo_idx;
      end
    end
    hv_prev = (hdr_valid === 1'b1);
  end

  task automatic set_hdr(input logic [23:0] w0, input logic [23:0] w1,
                         input logic [23:0] w2, input bit distinct);
    mem[0] = w0;
    mem[1] = w1;
    mem[2] = w2;
    for (int k = 0; k < 4; k++) begin
      mem[3 + 2 * k] = 24'h020000 + 24'(k) * 24'h010000;
      mem[4 + 2 * k] = distinct ? 24'h001111 * 24'(k + 1) : 24'h004000;
    end
  endtask

  task automatic check_reset_vals();
    check("rst_im_a", im.IM_A, 0);
    check("rst_im_wen", im.IM_WEN, 1);
    check("rst_bus_own", im.bus_own, 1);
    check("rst_hdr_valid", hdr_valid, 0);
    check("rst_fb_addr", fb_addr, 0);
    check("rst_photo_cnt", photo_cnt, 0);
    check("rst_photo_idx", photo_idx, 0);
    check("rst_photo_addr", photo_addr, 0);
    check("rst_photo_size", photo_size, 0);
    check("rst_time", hms_now(), 0);
    check("rst_time_req", time_req, 0);
    check("rst_photo_req", photo_req, 0);
    check("rst_overrun", overrun, 0);
  endtask

  // Returns on the first post-reset fetch cycle (IM_A = HDR_BASE).
  task automatic apply_reset(input bit chk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    if (chk) check_reset_vals();
    reset = 1'b0;
    fetch_cyc = cyc;
  endtask

  task automatic wait_hdr();
    int n = 0;
    while (hdr_valid !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("hdr_valid_within_budget", hdr_valid, 1);
  endtask

  task automatic drain_check(input string tag);
    check({tag, "_hdr_left"}, hq.size(), 0);
    check({tag, "_time_left"}, tq.size(), 0);
    check({tag, "_photo_left"}, pq.size(), 0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = '0;

    // Header fetch sweep and normal slideshow with immediate acks.
    set_hdr(24'h0A1E3B, 24'h100000, 24'd3, 1'b0);
    apply_reset(1'b1);
    check("sweep_im_a_0", im.IM_A, 0);
    check("sweep_bus_own_0", im.bus_own, 1);
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      check("sweep_im_a", im.IM_A, i);
      check("sweep_bus_own", im.bus_own, 1);
      check("sweep_im_wen", im.IM_WEN, 1);
    end
    hq.push_back('{13, 103059, 3, 'h100000, 'h020000, 'h004000, 1'b1});
    for (int i = 0; i < 6; i++) tq.push_back('{10 * (i + 1), 103100 + i});
    pq.push_back('{20, 1, 'h030000, 'h004000});
    pq.push_back('{40, 2, 'h040000, 'h004000});
    pq.push_back('{60, 0, 'h020000, 'h004000});
    wait_hdr();
    repeat (65) @(negedge clk);
    check("t1_overrun", overrun, 0);
    drain_check("t1");

    // 23:59:59 rollover, photo_num = 0 never requests a photo.
    set_hdr(24'h173B3B, 24'h123456, 24'd0, 1'b0);
    apply_reset(1'b0);
    preq_seen = 1'b0;
    hq.push_back('{13, 235959, 0, 'h123456, 'h020000, 'h004000, 1'b0});
    tq.push_back('{10, 0});
    tq.push_back('{20, 1});
    tq.push_back('{30, 2});
    wait_hdr();
    repeat (35) @(negedge clk);
    check("t2_photo_req_never", preq_seen, 0);
    check("t2_photo_idx_held", photo_idx, 0);
    drain_check("t2");

    // Out-of-range time loads 00:00:00; photo_num = 9 clamps to 4 and wraps 3->0.
    set_hdr(24'h1C4040, 24'hABCDEF, 24'd9, 1'b1);
    apply_reset(1'b0);
    hq.push_back('{13, 0, 4, 'hABCDEF, 'h020000, 'h001111, 1'b1});
    for (int i = 1; i <= 8; i++) tq.push_back('{10 * i, i});
    pq.push_back('{20, 1, 'h030000, 'h002222});
    pq.push_back('{40, 2, 'h040000, 'h003333});
    pq.push_back('{60, 3, 'h050000, 'h004444});
    pq.push_back('{80, 0, 'h020000, 'h001111});
    wait_hdr();
    repeat (85) @(negedge clk);
    check("t3_overrun", overrun, 0);
    drain_check("t3");

    // time_ack withheld across two ticks: req coalesces and overrun sticks.
    set_hdr(24'h0A1E3B, 24'h100000, 24'd3, 1'b0);
    time_ack = 1'b0;
    apply_reset(1'b0);
    hq.push_back('{13, 103059, 3, 'h100000, 'h020000, 'h004000, 1'b1});
    tq.push_back('{10, 103100});
    tq.push_back('{20, 103101});
    pq.push_back('{20, 1, 'h030000, 'h004000});
    wait_hdr();
    repeat (25) @(negedge clk);
    check("t4_time_req_held", time_req, 1);
    check("t4_overrun_set", overrun, 1);
    check("t4_photo_req_acked", photo_req, 0);
    time_ack = 1'b1;
    @(negedge clk);
    time_ack = 1'b0;
    check("t4_time_req_cleared", time_req, 0);
    check("t4_overrun_sticky", overrun, 1);
    drain_check("t4");

    // Reset mid-RUN: reset values next cycle and a fresh fetch from HDR_BASE.
    time_ack = 1'b1;
    apply_reset(1'b1);
    check("t5_restart_im_a_0", im.IM_A, 0);
    @(negedge clk);
    check("t5_restart_im_a_1", im.IM_A, 1);
    check("t5_restart_bus_own", im.bus_own, 1);
    hq.push_back('{13, 103059, 3, 'h100000, 'h020000, 'h004000, 1'b1});
    wait_hdr();
    @(negedge clk);
    check("t5_overrun_clear", overrun, 0);
    drain_check("t5");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
